// File: rtl/tsc_fetch_decode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tsc_fetch_decode_ctrl_pkg
// Shared definitions for the TSC fetch/decode/execute controller:
//   - FSM state encoding (IF, ID, EX, WB, HALT)
//   - opcode and R-type function constants
//   - instruction field bit positions
//   - sign-extension helper for the 8-bit immediate
// No ports (package).
// -----------------------------------------------------------------------------
package tsc_fetch_decode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd9;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RS_MSB   = 11;
  localparam int RS_LSB   = 10;
  localparam int RT_MSB   = 9;
  localparam int RT_LSB   = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 6;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;
  localparam int JMP_MSB  = 11;

  function automatic logic [15:0] sext_imm8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/tsc_fetch_decode_ctrl_if.sv
// -----------------------------------------------------------------------------
// tsc_fetch_decode_ctrl_if
// Bundles the memory fetch handshake and the register-file connection of the
// TSC controller.
//   readM/address      : fetch request and address (controller -> memory)
//   mem_data/inputReady: instruction word and response strobe (memory -> ctrl)
//   rf_addr1/rf_addr2  : RF read addresses (rs, rt)
//   rf_addr3/rf_write/rf_data3: RF write port
//   rf_data1/rf_data2  : RF read data
// Modports: master = controller side, slave = memory/RF side.
// -----------------------------------------------------------------------------
interface tsc_fetch_decode_ctrl_if #(
  parameter int PC_W = 16
);
  logic            readM;
  logic [PC_W-1:0] address;
  logic [15:0]     mem_data;
  logic            inputReady;
  logic [1:0]      rf_addr1;
  logic [1:0]      rf_addr2;
  logic [1:0]      rf_addr3;
  logic            rf_write;
  logic [15:0]     rf_data3;
  logic [15:0]     rf_data1;
  logic [15:0]     rf_data2;

  modport master (
    output readM, address, rf_addr1, rf_addr2, rf_addr3, rf_write, rf_data3,
    input  mem_data, inputReady, rf_data1, rf_data2
  );

  modport slave (
    input  readM, address, rf_addr1, rf_addr2, rf_addr3, rf_write, rf_data3,
    output mem_data, inputReady, rf_data1, rf_data2
  );
endinterface

// File: rtl/tsc_fetch_decode_ctrl_alu.sv
// -----------------------------------------------------------------------------
// tsc_alu
// Combinational ALU of the TSC datapath.
//   a, b : operands (W bits)
//   func : R-type function code (0..7 are arithmetic/logic operations)
//   y    : result; unknown function codes yield zero
// -----------------------------------------------------------------------------
module tsc_alu
  import tsc_fetch_decode_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [5:0]   func,
  output logic [W-1:0] y
);

  // Result selection by function code
  always_comb begin
    y = {W{1'b0}};
    case (func)
      FUNC_ADD: y = a + b;
      FUNC_SUB: y = a - b;
      FUNC_AND: y = a & b;
      FUNC_ORR: y = a | b;
      FUNC_NOT: y = ~a;
      FUNC_TCP: y = ~a + {{(W-1){1'b0}}, 1'b1};
      FUNC_SHL: y = {a[W-2:0], 1'b0};
      FUNC_SHR: y = {a[W-1], a[W-1:1]};
      default:  y = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/tsc_fetch_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tsc_fetch_decode_ctrl
// Multi-cycle IF -> ID -> EX -> WB controller for the 16-bit TSC datapath.
// Fetches over a readM/inputReady handshake, decodes, runs the ALU and writes
// the result back into the external 4x16 register file.
// Ports:
//   clk         : clock, all state on posedge
//   reset       : synchronous active-high reset
//   bus         : tsc_fetch_decode_ctrl_if.master (memory + RF signals)
//   num_inst    : retired-instruction count (wraps)
//   output_port : value captured by WWD
// Build option: define TSC_HALT_EN to make R-type func 29 (HLT) park the FSM
// in a HALT state that only reset leaves; otherwise func 29 is a NOP.
// -----------------------------------------------------------------------------
module tsc_fetch_decode_ctrl
  import tsc_fetch_decode_ctrl_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  tsc_fetch_decode_ctrl_if.master    bus,
  output logic [15:0]                num_inst,
  output logic [15:0]                output_port
);

  state_t              state_r;
  state_t              state_nx;
  logic [PC_W-1:0]     pc_r;
  logic [PC_W-1:0]     next_pc_r;
  logic [DATA_W-1:0]   ir_r;
  logic                read_m_r;
  logic                rf_write_r;
  logic [1:0]          rf_addr3_r;
  logic [DATA_W-1:0]   rf_data3_r;
  logic [15:0]         num_inst_r;
  logic [DATA_W-1:0]   output_port_r;

  logic [3:0]          opcode_s;
  logic [5:0]          func_s;
  logic [1:0]          rs_s;
  logic [1:0]          rt_s;
  logic [1:0]          rd_s;
  logic [7:0]          imm_s;
  logic                is_alu_s;
  logic                is_wwd_s;
  logic                is_adi_s;
  logic                is_lhi_s;
  logic                is_jmp_s;
`ifdef TSC_HALT_EN
  logic                is_hlt_s;
`endif
  logic                writes_s;
  logic [1:0]          waddr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W-1:0]   alu_b_s;
  logic [5:0]          alu_func_s;
  logic [DATA_W-1:0]   alu_y_s;
  logic [PC_W-1:0]     pc_inc_s;
  logic [PC_W-1:0]     jmp_pc_s;
  logic                fetch_done_s;

  // Instruction fields
  assign opcode_s = ir_r[OPC_MSB:OPC_LSB];
  assign func_s   = ir_r[FUNC_MSB:FUNC_LSB];
  assign rs_s     = ir_r[RS_MSB:RS_LSB];
  assign rt_s     = ir_r[RT_MSB:RT_LSB];
  assign rd_s     = ir_r[RD_MSB:RD_LSB];
  assign imm_s    = ir_r[IMM_MSB:IMM_LSB];

  // An inputReady strobe only counts while a request is outstanding
  assign fetch_done_s = read_m_r & bus.inputReady;

  // Instruction classification
  always_comb begin
    is_alu_s = 1'b0;
    is_wwd_s = 1'b0;
    is_adi_s = 1'b0;
    is_lhi_s = 1'b0;
    is_jmp_s = 1'b0;
`ifdef TSC_HALT_EN
    is_hlt_s = 1'b0;
`endif
    case (opcode_s)
      OP_RTYPE: begin
        if (func_s <= FUNC_SHR) begin
          is_alu_s = 1'b1;
        end else if (func_s == FUNC_WWD) begin
          is_wwd_s = 1'b1;
`ifdef TSC_HALT_EN
        end else if (func_s == FUNC_HLT) begin
          is_hlt_s = 1'b1;
`endif
        end else begin
          is_alu_s = 1'b0;
        end
      end
      OP_ADI:  is_adi_s = 1'b1;
      OP_LHI:  is_lhi_s = 1'b1;
      OP_JMP:  is_jmp_s = 1'b1;
      default: is_alu_s = 1'b0;
    endcase
  end

  // ADI reuses the ALU adder with the sign-extended immediate as operand B
  assign alu_b_s    = is_adi_s ? sext_imm8(imm_s) : bus.rf_data2;
  assign alu_func_s = is_adi_s ? FUNC_ADD : func_s;

  tsc_alu #(.W(DATA_W)) u_alu (
    .a    (bus.rf_data1),
    .b    (alu_b_s),
    .func (alu_func_s),
    .y    (alu_y_s)
  );

  assign writes_s = is_alu_s | is_adi_s | is_lhi_s;
  assign waddr_s  = is_alu_s ? rd_s : rt_s;
  assign wdata_s  = is_lhi_s ? {imm_s, 8'h00} : alu_y_s;
  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign jmp_pc_s = {pc_r[PC_W-1:JMP_MSB+1], ir_r[JMP_MSB:0]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IF;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IF: begin
        if (fetch_done_s) begin
          state_nx = ST_ID;
        end else begin
          state_nx = ST_IF;
        end
      end
      ST_ID: state_nx = ST_EX;
      ST_EX: state_nx = ST_WB;
`ifdef TSC_HALT_EN
      ST_WB: begin
        if (is_hlt_s) begin
          state_nx = ST_HALT;
        end else begin
          state_nx = ST_IF;
        end
      end
      ST_HALT: state_nx = ST_HALT;
`else
      ST_WB: state_nx = ST_IF;
`endif
      default: state_nx = ST_IF;
    endcase
  end

  // Datapath registers: fetch, execute latch and write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= {PC_W{1'b0}};
      next_pc_r     <= {PC_W{1'b0}};
      ir_r          <= {DATA_W{1'b0}};
      read_m_r      <= 1'b0;
      rf_write_r    <= 1'b0;
      rf_addr3_r    <= 2'd0;
      rf_data3_r    <= {DATA_W{1'b0}};
      num_inst_r    <= 16'd0;
      output_port_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IF: begin
          // First IF cycle after reset raises the request; later IF cycles
          // arrive with it already raised by WB.
          if (fetch_done_s) begin
            ir_r     <= bus.mem_data;
            read_m_r <= 1'b0;
          end else begin
            read_m_r <= 1'b1;
          end
        end
        ST_ID: begin
          read_m_r <= 1'b0;
        end
        ST_EX: begin
          rf_write_r <= writes_s;
          rf_addr3_r <= waddr_s;
          rf_data3_r <= wdata_s;
          next_pc_r  <= is_jmp_s ? jmp_pc_s : pc_inc_s;
        end
        ST_WB: begin
          rf_write_r <= 1'b0;
          num_inst_r <= num_inst_r + 16'd1;
          if (is_wwd_s) begin
            output_port_r <= bus.rf_data1;
          end else begin
            output_port_r <= output_port_r;
          end
`ifdef TSC_HALT_EN
          // HLT keeps pc at its own address and never re-requests
          if (is_hlt_s) begin
            read_m_r <= 1'b0;
          end else begin
            pc_r     <= next_pc_r;
            read_m_r <= 1'b1;
          end
`else
          pc_r     <= next_pc_r;
          read_m_r <= 1'b1;
`endif
        end
`ifdef TSC_HALT_EN
        ST_HALT: begin
          read_m_r <= 1'b0;
        end
`endif
        default: begin
          read_m_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readM    = read_m_r;
  assign bus.address  = pc_r;
  assign bus.rf_addr1 = rs_s;
  assign bus.rf_addr2 = rt_s;
  assign bus.rf_addr3 = rf_addr3_r;
  assign bus.rf_write = rf_write_r;
  assign bus.rf_data3 = rf_data3_r;
  assign num_inst     = num_inst_r;
  assign output_port  = output_port_r;

endmodule

// File: tb/tb_tsc_fetch_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tsc_fetch_decode_ctrl
// Bench for tsc_fetch_decode_ctrl: a memory responder with random wait states
// feeds a directed prologue followed by random instructions. At each fetch an
// instruction-level model computes the expected retirement (RF write, output
// port, next pc, count) and queues it; a monitor compares on each retirement.
// -----------------------------------------------------------------------------
module tb_tsc_fetch_decode_ctrl;

  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] outp;
    logic [15:0] npc;
    logic [15:0] cnt;
    logic        halt;
  } exp_t;

  localparam int N_INSTR = 250;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] num_inst;
  logic [15:0] output_port;

  tsc_fetch_decode_ctrl_if #(.PC_W(16)) bus ();

  tsc_fetch_decode_ctrl #(.PC_W(16), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .num_inst    (num_inst),
    .output_port (output_port)
  );

  always #5 clk = ~clk;

  // Register file model: combinational reads, write on posedge
  logic [15:0] rf [4] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (bus.rf_write) rf[bus.rf_addr3] <= bus.rf_data3;
  end
  assign bus.rf_data1 = rf[bus.rf_addr1];
  assign bus.rf_data2 = rf[bus.rf_addr2];

  logic [15:0] mem [0:65535];

  // Instruction-level reference state
  logic [15:0] m_reg [4];
  logic [15:0] m_pc;
  logic [15:0] m_out;
  logic [15:0] m_cnt;
  bit          m_halt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   resp_en    = 1'b0;
  bit   mon_en     = 1'b0;
  bit   stop_fetch = 1'b0;
  logic [15:0] prev_num;
  int   wr_cnt;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Execute one instruction on the ISA-level model and describe its retirement
  task automatic model_step(input logic [15:0] ins, output exp_t e);
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] nxt;
    op  = ins[15:12];
    fn  = ins[5:0];
    a   = m_reg[ins[11:10]];
    b   = m_reg[ins[9:8]];
    nxt = m_pc + 16'd1;
    e.wr = 1'b0; e.waddr = 2'd0; e.wdata = 16'h0000; e.halt = 1'b0;
    if (op == 4'd15) begin
      e.waddr = ins[7:6];
      e.wr    = (fn < 6'd8);
      case (fn)
        6'd0: e.wdata = a + b;
        6'd1: e.wdata = a - b;
        6'd2: e.wdata = a & b;
        6'd3: e.wdata = a | b;
        6'd4: e.wdata = 16'hFFFF ^ a;
        6'd5: e.wdata = 16'h0000 - a;
        6'd6: e.wdata = a * 16'd2;
        6'd7: e.wdata = 16'($signed(a) >>> 1);
        6'd28: m_out = a;
`ifdef TSC_HALT_EN
        6'd29: begin m_halt = 1'b1; nxt = m_pc; e.halt = 1'b1; end
`endif
        default: ;
      endcase
    end else if (op == 4'd4) begin
      e.wr = 1'b1; e.waddr = ins[9:8];
      e.wdata = a + 16'($signed(ins[7:0]));
    end else if (op == 4'd6) begin
      e.wr = 1'b1; e.waddr = ins[9:8];
      e.wdata = 16'(ins[7:0]) * 16'd256;
    end else if (op == 4'd9) begin
      nxt = (m_pc & 16'hF000) | (ins & 16'h0FFF);
    end
    if (e.wr) m_reg[e.waddr] = e.wdata;
    m_cnt = m_cnt + 16'd1;
    m_pc  = nxt;
    e.npc = nxt; e.cnt = m_cnt; e.outp = m_out;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin w[15:12] = 4'hF; w[5:0] = 6'($urandom_range(0, 7)); end
      4: begin w[15:12] = 4'hF; w[5:0] = ($urandom_range(0, 1) == 0) ? 6'd28 : 6'd30; end
      5: w[15:12] = 4'h4;
      6: w[15:12] = 4'h6;
      7: w[15:12] = 4'h9;
      8: w[15:12] = 4'($urandom_range(0, 3));
      default: ;
    endcase
    return w;
  endfunction

  // Memory responder: random wait states, garbage data when not responding
  initial begin
    int   wait_left;
    exp_t e;
    wait_left = 0;
    bus.inputReady = 1'b0;
    bus.mem_data   = 16'h0000;
    forever begin
      @(negedge clk);
      if (resp_en && bus.readM && !stop_fetch) begin
        if (wait_left > 0) begin
          wait_left--;
          bus.inputReady = 1'b0;
          bus.mem_data   = 16'($urandom);
        end else begin
          chk("fetch_addr", bus.address, m_pc);
          bus.mem_data   = mem[bus.address];
          bus.inputReady = 1'b1;
          model_step(mem[bus.address], e);
          exp_q.push_back(e);
          wait_left = $urandom_range(0, 3);
        end
      end else begin
        // Strobes without an outstanding request must be ignored
        bus.inputReady = resp_en && !bus.readM && ($urandom_range(0, 3) == 0);
        bus.mem_data   = 16'($urandom);
      end
    end
  end

  // Retirement monitor: a change of num_inst marks the end of a WB cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.rf_write) begin
          wr_cnt++;
          wr_addr = bus.rf_addr3;
          wr_data = bus.rf_data3;
        end
        if (num_inst !== prev_num) begin
          prev_num = num_inst;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL retire_unexpected: got num_inst 0x%04h, expected no retirement", num_inst);
          end else begin
            e = exp_q.pop_front();
            chk("num_inst", num_inst, e.cnt);
            chk("output_port", output_port, e.outp);
            chk("next_address", bus.address, e.npc);
            chk("rf_write_pulses", 16'(wr_cnt), 16'(e.wr));
            if (e.wr) begin
              chk("rf_addr3", 16'(wr_addr), 16'(e.waddr));
              chk("rf_data3", wr_data, e.wdata);
            end
            if (e.halt) chk("halt_readM", 16'(bus.readM), 16'h0000);
          end
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    int cyc;
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = rand_instr();
    mem[0] = 16'h4105;   // ADI r1,r0,5
    mem[1] = 16'h42FF;   // ADI r2,r0,-1
    mem[2] = 16'hF600;   // ADD r0,r1,r2
    mem[3] = 16'hF41C;   // WWD r1
    mem[4] = 16'h62AB;   // LHI r2,0xAB
    mem[5] = 16'hF01D;   // HLT (NOP without the halt option)
    mem[6] = 16'h9FFF;   // JMP 0x0FFF
    mem[16'h0FFF] = 16'h0000;
    mem[16'h1000] = 16'h9FFF;
    mem[16'h1FFF] = 16'h0000;
    mem[16'h2000] = 16'h9FFF;
    mem[16'h2FFF] = 16'h9123; // JMP across the 0x2FFF page -> 0x2123
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
    m_pc = 16'h0000; m_out = 16'h0000; m_cnt = 16'h0000; m_halt = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_readM", 16'(bus.readM), 16'h0000);
    chk("rst_address", bus.address, 16'h0000);
    chk("rst_num_inst", num_inst, 16'h0000);
    chk("rst_output_port", output_port, 16'h0000);
    chk("rst_rf_write", 16'(bus.rf_write), 16'h0000);
    chk("rst_rf_addr1", 16'(bus.rf_addr1), 16'h0000);
    chk("rst_rf_addr2", 16'(bus.rf_addr2), 16'h0000);
    chk("rst_rf_addr3", 16'(bus.rf_addr3), 16'h0000);
    chk("rst_rf_data3", bus.rf_data3, 16'h0000);

    reset = 1'b0;
    @(negedge clk);
    chk("if_readM", 16'(bus.readM), 16'h0001);
    chk("if_address", bus.address, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait_readM", 16'(bus.readM), 16'h0001);
      chk("wait_address", bus.address, 16'h0000);
      chk("wait_num_inst", num_inst, 16'h0000);
    end

    reset = 1'b1;           // reset in the middle of IF
    @(negedge clk);
    chk("midif_readM", 16'(bus.readM), 16'h0000);
    chk("midif_address", bus.address, 16'h0000);
    chk("midif_num_inst", num_inst, 16'h0000);

    reset    = 1'b0;
    prev_num = 16'h0000;
    wr_cnt   = 0;
    mon_en   = 1'b1;
    resp_en  = 1'b1;

    cyc = 0;
    while (!(m_cnt >= 16'(N_INSTR) || m_halt) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    stop_fetch = 1'b1;
    chk("progress", 16'(m_cnt >= 16'(N_INSTR) || m_halt), 16'h0001);
    while (exp_q.size() != 0 && cyc < 25000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 16'(exp_q.size()), 16'h0000);

`ifdef TSC_HALT_EN
    if (m_halt) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("halt_hold_readM", 16'(bus.readM), 16'h0000);
        chk("halt_hold_num_inst", num_inst, m_cnt);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tsc_fetch_decode_ctrl.md
Name: tsc_fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller for the 16-bit TSC datapath.
- Sits directly upstream of the 4x16 register file: drives its read addresses, write address, write enable and write data; consumes both read ports.
- Fetches instructions over a simple memory read handshake, decodes them, performs the ALU operation internally and writes the result back.

Parameters:
- PC_W, 16, width of program counter and memory address.
- DATA_W, 16, datapath/instruction width; fixed by ISA, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- readM  out  1  memory read request.
- address  out  PC_W  fetch address (= pc).
- mem_data  in  16  instruction word, valid while inputReady=1.
- inputReady  in  1  memory response strobe.
- rf_addr1  out  2  RF read address 1 (rs).
- rf_addr2  out  2  RF read address 2 (rt).
- rf_addr3  out  2  RF write address.
- rf_write  out  1  RF write enable, one-cycle pulse.
- rf_data3  out  16  RF write data.
- rf_data1  in  16  RF read data 1.
- rf_data2  in  16  RF read data 2.
- num_inst  out  16  retired-instruction count.
- output_port  out  16  WWD output register.

Behaviour:
- Reset (sampled on posedge with reset=1):
  - pc=0, state=IF, readM=0, rf_write=0, num_inst=0, output_port=0, ir=0.
  - rf_addr* and rf_data3 are 0.
  - Reset in any state aborts the instruction with no RF write.
- State machine: IF -> ID -> EX -> WB -> IF.
- IF: readM=1 and address=pc, held until inputReady=1 is sampled. On that edge: ir<=mem_data, readM<=0, go to ID. inputReady while readM=0 is ignored.
- ID: rf_addr1=ir[11:10], rf_addr2=ir[9:8] (combinational from ir). Go to EX.
- EX: latch result from rf_data1/rf_data2/imm; compute next_pc. Go to WB.
- WB:
  - rf_write=1 for exactly this cycle if the instruction writes.
  - pc<=next_pc, num_inst<=num_inst+1 (wraps 0xFFFF->0).
  - Go to IF.
- Latency: 4 cycles + memory wait per instruction.
- Decode (opcode=ir[15:12]):
  - opcode 15 R-type, rd=ir[7:6], func=ir[5:0]:
    - 0 ADD, 1 SUB (A-B), 2 AND, 3 ORR, 4 NOT (~A), 5 TCP (-A), 6 SHL (A<<1), 7 SHR (arithmetic A>>>1).
    - Result to rd.
    - 28 WWD: output_port<=rf_data1 in WB, no RF write.
  - opcode 4 ADI: rt <= rs + sign_extend(ir[7:0]).
  - opcode 6 LHI: rt <= {ir[7:0], 8'h00}.
  - opcode 9 JMP: next_pc={pc[15:12], ir[11:0]}, no RF write.
  - Any other opcode/func: NOP, num_inst still increments.
- Arithmetic: all 16-bit, overflow discarded; next_pc default pc+1, wraps 0xFFFF->0.
- rf_addr3 and rf_data3 are registered, stable during the WB cycle.

Optional Feature:
- Macro: TSC_HALT_EN.
- Defined: R-type func 29 (HLT) moves the FSM to a HALT state after WB.
  - num_inst is incremented; pc stays at the HLT address.
  - readM stays 0; state is left only by reset.
- Undefined: func 29 is a NOP; no HALT state exists.

Decomposition:
- Shared package holds:
  - State encoding (IF, ID, EX, WB, HALT).
  - Opcode constants: OP_RTYPE=15, OP_ADI=4, OP_LHI=6, OP_JMP=9.
  - Func constants: 0-7, WWD=28, HLT=29.
  - Instruction field bit ranges.
- One natural sub-module: tsc_alu (combinational A, B, func -> result), instantiated in EX.

Test Plan:
- Reset mid-IF with readM=1 -> next cycle readM=0, pc=0, num_inst=0; after release readM=1 with address=0.
- mem[0]=0x4105 (ADI r1,r0,5), R0=0 -> single WB cycle with rf_write=1, rf_addr3=1, rf_data3=0x0005; num_inst=1; address=1 on next IF.
- inputReady held low for 5 cycles in IF -> readM stays 1, address stable, no state advance; ir captured on the inputReady edge.
- R1=0x0005, R2=0xFFFF, instruction 0xF600 (ADD r0,r1,r2) -> rf_data3=0x0004, rf_addr3=0; then 0xF41C (WWD r1) -> output_port=0x0005, rf_write stays 0.
- pc=0x2FFF fetching 0x9123 (JMP) -> next address=0x2123; LHI 0x62AB -> rf_addr3=2, rf_data3=0xAB00.
- TSC_HALT_EN defined, instruction 0xF01D -> HALT entered, readM=0 for 20 cycles, num_inst incremented once; undefined -> execution continues at pc+1.
